// File: rtl/vga_grid_reader_pkg.sv
// Shared VGA timing, playfield geometry and RGB332 layout for the grid reader,
// VGA_Mem and game logic.
package vga_grid_reader_pkg;

    // 640x480@60 timing, pixels / lines
    localparam int unsigned H_ACT        = 640;
    localparam int unsigned H_FP         = 16;
    localparam int unsigned H_SYNC       = 96;
    localparam int unsigned H_BP         = 48;
    localparam int unsigned H_TOTAL      = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_ACT + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int unsigned V_ACT        = 480;
    localparam int unsigned V_FP         = 10;
    localparam int unsigned V_SYNC       = 2;
    localparam int unsigned V_BP         = 33;
    localparam int unsigned V_TOTAL      = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_ACT + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Playfield geometry
    localparam int unsigned GRID_W  = 10;
    localparam int unsigned GRID_H  = 20;
    localparam int unsigned CELL_SH = 4;
    localparam int unsigned X0      = 240;
    localparam int unsigned Y0      = 80;
    localparam int unsigned X1      = X0 + (GRID_W << CELL_SH);
    localparam int unsigned Y1      = Y0 + (GRID_H << CELL_SH);

    // Video outputs trail the counters by this many clocks
    localparam int unsigned PIPE_LAT = 3;

    // RGB332 field positions
    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_LSB = 5;
    localparam int unsigned G_MSB = 4;
    localparam int unsigned G_LSB = 2;
    localparam int unsigned B_MSB = 1;
    localparam int unsigned B_LSB = 0;

    localparam logic [7:0] BORDER = 8'h49;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Cell address of an in-grid pixel: row * GRID_W + col
    function automatic logic [15:0] cell_addr(input logic [9:0] h, input logic [9:0] v);
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [15:0] row;
        logic [15:0] col;
        dx  = h - 10'(X0);
        dy  = v - 10'(Y0);
        row = 16'(dy >> CELL_SH);
        col = 16'(dx >> CELL_SH);
        return row * 16'(GRID_W) + col;
    endfunction

endpackage

// File: rtl/vga_grid_reader_if.sv
// Port-B read bus and DAC outputs of the grid reader.
interface vga_grid_reader_if;
    logic [15:0] addr_b;
    logic [7:0]  q_b;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        frame_start;

    modport master (
        output addr_b, red, green, blue, hsync, vsync, blank, frame_start,
        input  q_b
    );

    modport slave (
        input  addr_b, red, green, blue, hsync, vsync, blank, frame_start,
        output q_b
    );
endinterface

// File: rtl/vga_grid_reader_timing.sv
// Free-running 800x525 VGA counters with stage-0 sync/active decode and a
// frame_start pulse on the wrap to (0,0).
module vga_grid_reader_timing
    import vga_grid_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt == 10'(V_TOTAL - 1));

    // Pixel/line counters; frame_start is registered so reset itself never pulses it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= h_last && v_last;
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Stage-0 decode of the current counter position
    always_comb begin
        active = (h_cnt < 10'(H_ACT)) && (v_cnt < 10'(V_ACT));
        hsync  = !((h_cnt >= 10'(H_SYNC_START)) && (h_cnt < 10'(H_SYNC_END)));
        vsync  = !((v_cnt >= 10'(V_SYNC_START)) && (v_cnt < 10'(V_SYNC_END)));
    end

endmodule

// File: rtl/vga_grid_reader.sv
// Read-side VGA client: timing, cell address generation, and a 3-stage pipeline
// aligning video outputs with the registered VGA_Mem port-B read.
module vga_grid_reader
    import vga_grid_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    vga_grid_reader_if.master bus
);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        active0;
    logic        hsync0;
    logic        vsync0;
    logic        in_grid0;
    logic        frame_start;

    logic [15:0] addr_q;
    logic        act1, grid1, hs1, vs1;
    logic        act2, grid2, hs2, vs2;
    rgb332_t     rgb_q;
    logic        hs3, vs3, blank_q;

    vga_grid_reader_timing u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active0),
        .hsync       (hsync0),
        .vsync       (vsync0),
        .frame_start (frame_start)
    );

    // Stage-0 playfield membership
    always_comb begin
        in_grid0 = active0
                && (h_cnt >= 10'(X0)) && (h_cnt < 10'(X1))
                && (v_cnt >= 10'(Y0)) && (v_cnt < 10'(Y1));
    end

    // Stage 1: issue the port-B address, carry control alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            act1   <= 1'b0;
            grid1  <= 1'b0;
            hs1    <= 1'b1;
            vs1    <= 1'b1;
        end else begin
            addr_q <= in_grid0 ? cell_addr(h_cnt, v_cnt) : '0;
            act1   <= active0;
            grid1  <= in_grid0;
            hs1    <= hsync0;
            vs1    <= vsync0;
        end
    end

    // Stage 2: VGA_Mem is registering the read, only control moves here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act2  <= 1'b0;
            grid2 <= 1'b0;
            hs2   <= 1'b1;
            vs2   <= 1'b1;
        end else begin
            act2  <= act1;
            grid2 <= grid1;
            hs2   <= hs1;
            vs2   <= vs1;
        end
    end

    // Stage 3: pick cell colour, border or black and register the DAC outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            hs3     <= 1'b1;
            vs3     <= 1'b1;
            blank_q <= 1'b1;
        end else begin
            rgb_q   <= !act2 ? rgb332_t'('0) : grid2 ? rgb332_t'(bus.q_b) : rgb332_t'(BORDER);
            hs3     <= hs2;
            vs3     <= vs2;
            blank_q <= !act2;
        end
    end

    assign bus.addr_b      = addr_q;
    assign bus.red         = rgb_q.r;
    assign bus.green       = rgb_q.g;
    assign bus.blue        = rgb_q.b;
    assign bus.hsync       = hs3;
    assign bus.vsync       = vs3;
    assign bus.blank       = blank_q;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_vga_grid_reader.sv
// Self-checking bench for vga_grid_reader: a clock-count model of the raster
// predicts every output each cycle; random VGA_Mem contents and reset timing.
module tb_vga_grid_reader;

    localparam int unsigned LINE     = 800;
    localparam int unsigned FRAME    = 800 * 525;
    localparam int unsigned MAX_FAIL = 100;

    logic clk;
    logic rst_n;
    vga_grid_reader_if bus();

    vga_grid_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VGA_Mem port B stand-in: registered read
    logic [7:0] mem [0:255];
    always @(posedge clk) bus.q_b <= mem[bus.addr_b[7:0]];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned k;   // clock edges since the last reset release

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // Raster position p -> {rgb[7:0], hsync, vsync, blank}
    function automatic logic [10:0] exp_video(input int unsigned p);
        int unsigned h, v;
        logic act, grid;
        logic [7:0] c;
        h    = p % LINE;
        v    = p / LINE;
        act  = (h < 640) && (v < 480);
        grid = act && (h >= 240) && (h < 400) && (v >= 80) && (v < 400);
        if (!act)      c = 8'h00;
        else if (grid) c = mem[((v - 80) / 16) * 10 + (h - 240) / 16];
        else           c = 8'h49;
        return {c, !((h >= 656) && (h < 752)), !((v >= 490) && (v < 492)), !act};
    endfunction

    function automatic logic [15:0] exp_addr(input int unsigned p);
        int unsigned h, v;
        h = p % LINE;
        v = p / LINE;
        if ((h >= 240) && (h < 400) && (v >= 80) && (v < 400))
            return 16'(((v - 80) / 16) * 10 + (h - 240) / 16);
        return 16'd0;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"},   {bus.red, bus.green, bus.blue}, 32'h0);
        check({tag, "_sync"},  {bus.hsync, bus.vsync, bus.blank}, 32'h7);
        check({tag, "_addr"},  bus.addr_b, 32'h0);
        check({tag, "_fs"},    bus.frame_start, 32'h0);
    endtask

    // Per-cycle compare against the model, plus hand-computed anchors
    always @(negedge clk) begin
        logic [10:0] act_v;
        act_v = {bus.red, bus.green, bus.blue, bus.hsync, bus.vsync, bus.blank};
        if (!rst_n) begin
            check_reset_state("in_reset");
        end else begin
            check("video", act_v, (k < 3) ? 11'h007 : exp_video((k - 3) % FRAME));
            check("addr_b", bus.addr_b, (k < 1) ? 16'h0 : exp_addr((k - 1) % FRAME));
            check("frame_start", bus.frame_start, (k > 0) && (k % FRAME == 0));
            case (k)
                658:    check("lit_hsync_pre",    bus.hsync, 1);
                659:    check("lit_hsync_fall",   bus.hsync, 0);
                754:    check("lit_hsync_last",   bus.hsync, 0);
                755:    check("lit_hsync_rise",   bus.hsync, 1);
                8703:   check("lit_700_10",       {bus.red, bus.green, bus.blue, bus.blank}, 9'h001);
                64242:  check("lit_239_80",       {bus.red, bus.green, bus.blue}, 8'h49);
                64243:  check("lit_240_80",       {bus.red, bus.green, bus.blue}, 8'hE0);
                64403:  check("lit_400_80",       {bus.red, bus.green, bus.blue}, 8'h49);
                319600: check("lit_addr_199",     bus.addr_b, 199);
                319602: check("lit_399_399_blue", bus.blue, 3);
                392002: check("lit_vsync_pre",    bus.vsync, 1);
                392003: check("lit_vsync_fall",   bus.vsync, 0);
                393602: check("lit_vsync_last",   bus.vsync, 0);
                393603: check("lit_vsync_rise",   bus.vsync, 1);
                419999: check("lit_fs_pre",       bus.frame_start, 0);
                420000: check("lit_fs",           bus.frame_start, 1);
                default: ;
            endcase
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0]   = 8'hE0;
        mem[199] = 8'h03;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n && n_fail < MAX_FAIL; i++) @(posedge clk);
        #2;
    endtask

    initial begin
        fill_mem();
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(300 + $urandom_range(0, 99));

        // Mid-line reset held for 10 clocks
        rst_n = 1'b0;
        #1 check_reset_state("async_assert");
        run(10);
        rst_n = 1'b1;

        // Run into line 300, then pulse reset for one clock
        run(300 * LINE + $urandom_range(0, LINE - 1));
        rst_n = 1'b0;
        #1 check_reset_state("pulse_assert");
        fill_mem();
        run(1);
        rst_n = 1'b1;

        // One full frame plus margin so the first frame_start is seen
        run(FRAME + 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
